mbus_bridge: RTL

- Memory-bus bridge directly downstream of the CPU core's memory bus (address/data-out/write-enable/data-in).
- Converts the CPU's single-cycle bus accesses into a req/ack handshake toward slower external memory or peripherals.
- Returns a wait signal for the phase scheduler to stall on.
- Detects and flags ack timeouts so a dead slave cannot hang the core.

---
 rtl/mbus_bridge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mbus_bridge.sv
// CPU memory-bus to req/ack bridge with ack timeout and sticky error flag.
// Optional one-entry read buffer enabled by defining MBUS_BRIDGE_RBUF_EN.
module mbus_bridge #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] cpu_aout,
    input  logic [WIDTH-1:0]     cpu_dout,
    input  logic                 cpu_wen,
    input  logic                 cpu_req,
    output logic [WIDTH-1:0]     cpu_din,
    output logic                 cpu_wait,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_we,
    output logic                 mem_req,
    input  logic                 mem_ack,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 err,
    output logic [1:0]           stat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t               state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [WIDTH-1:0]     din_n, wdata_n;
    logic [ADDR_SIZE-1:0] addr_n;
    logic                 we_n, req_n, err_n;

`ifdef MBUS_BRIDGE_RBUF_EN
    logic                 rb_valid, rb_valid_n;
    logic [ADDR_SIZE-1:0] rb_addr, rb_addr_n;
    logic [WIDTH-1:0]     rb_data, rb_data_n;
    logic                 rb_hit;

    assign rb_hit = rb_valid && !cpu_wen && (cpu_aout == rb_addr);
`endif

    assign cpu_wait = reset & cpu_req & (state != S_DONE);
    assign stat     = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        din_n   = cpu_din;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        we_n    = mem_we;
        req_n   = mem_req;
        err_n   = err;
`ifdef MBUS_BRIDGE_RBUF_EN
        rb_valid_n = rb_valid;
        rb_addr_n  = rb_addr;
        rb_data_n  = rb_data;
`endif
        unique case (state)
            S_IDLE: begin
                if (cpu_req) begin
`ifdef MBUS_BRIDGE_RBUF_EN
                    if (rb_hit) begin
                        din_n   = rb_data;
                        state_n = S_DONE;
                    end else
`endif
                    begin
                        addr_n  = cpu_aout;
                        wdata_n = cpu_dout;
                        we_n    = cpu_wen;
                        req_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // ack takes priority over the timeout limit in the same cycle
                if (mem_ack) begin
                    req_n   = 1'b0;
                    state_n = S_DONE;
                    if (!mem_we) begin
                        din_n = mem_rdata;
                    end
`ifdef MBUS_BRIDGE_RBUF_EN
                    if (!mem_we) begin
                        rb_valid_n = 1'b1;
                        rb_addr_n  = mem_addr;
                        rb_data_n  = mem_rdata;
                    end else if (mem_addr == rb_addr) begin
                        rb_data_n  = mem_wdata;
                    end
`endif
                end else if (cnt == CNT_LAST) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = S_DONE;
                    if (!mem_we) begin
                        din_n = '1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cpu_din   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_req   <= 1'b0;
            err       <= 1'b0;
`ifdef MBUS_BRIDGE_RBUF_EN
            rb_valid  <= 1'b0;
            rb_addr   <= '0;
            rb_data   <= '0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cpu_din   <= din_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= we_n;
            mem_req   <= req_n;
            err       <= err_n;
`ifdef MBUS_BRIDGE_RBUF_EN
            rb_valid  <= rb_valid_n;
            rb_addr   <= rb_addr_n;
            rb_data   <= rb_data_n;
`endif
        end
    end

endmodule
